mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
Parametrised successor to the core's fixed single-cycle memory stage. It sits between the ALU/execute logic and writeback and adds a valid/ready handshake to a variable-latency data memory (req/ack). It also adds byte/half/word access with byte enables and sign/zero extension, misalignment detection, and pending-destination outputs for the hazard unit. Every accepted op produces exactly one out_valid pulse toward writeback.

Parameters:
DW, 32, data width in bits (32 or 64); LB = log2(DW/8) address lane bits
AW, 32, address width
RSELW, 4, register-select width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  op presented by execute
in_ready  out  1  stage accepts the op this cycle
in_alu_data  in  AW  address (mem ops) or ALU result (non-mem ops)
in_reg_data  in  DW  store data
in_mem_we  in  1  store op
in_mem_re  in  1  load op
in_size  in  2  0 byte, 1 half, 2 word, 3 dword (DW=64 only)
in_signed  in  1  sign-extend load result
in_regs_we  in  1  op writes a register
in_regs_wsel  in  RSELW  destination register
d_req  out  1  memory request
d_addr  out  AW  request address, lane bits forced to 0
d_we  out  1  write request
d_be  out  DW/8  byte enables
d_data_w  out  DW  lane-replicated store data
d_ack  in  1  request complete; d_data_r valid this cycle
d_data_r  in  DW  read data
out_valid  out  1  result for writeback, one-cycle pulse
out_data  out  DW  result
out_wsel  out  RSELW  destination register
out_we  out  1  register write enable; qualified by out_valid
misalign  out  1  pulse with out_valid for a faulted access
pend_we  out  1  stage holds an op that will write a register
pend_wsel  out  RSELW  that op's destination

Behaviour:
- Reset state: IDLE. All registered fields are 0. Every output is 0 except in_ready, which is 1.
- A reset asserted mid-request abandons the request. d_req is 0 after that edge, and a late d_ack is ignored.
- States:
  - IDLE: nothing held.
  - PASS: holds a non-mem result; out_valid=1.
  - MEM: d_req=1, waiting for d_ack.
  - RESP: holds a load/store result; out_valid=1.
- in_ready = (state != MEM). An op is accepted on a cycle with in_valid && in_ready.
- Accepting a non-mem op at cycle t: PASS at t+1 with out_data = in_alu_data zero-extended to DW. This is one-cycle latency, the same as the existing stage.
- Accepting a mem op at t: MEM at t+1. d_req, d_addr, d_we, d_be and d_data_w are all registered and held stable until the ack cycle.
- d_ack in cycle k while in MEM: RESP at k+1. Minimum latency is accept at t, ack at t+1, out_valid at t+2.
- d_ack outside MEM is ignored.
- Leaving PASS, RESP or IDLE: the next state follows the op accepted this cycle; with no op, go to IDLE. PASS→PASS gives full throughput for non-mem ops.
- in_mem_we and in_mem_re both set: treated as a store.
- Store: out_we=0. out_valid still pulses, in RESP.
- Alignment, with a = in_alu_data[LB-1:0] and size bytes s = 1<<in_size:
  - Fault if a mod s != 0, or if in_size=3 with DW=32.
  - On a fault: no d_req. The op goes to RESP at t+1 with misalign=1, out_we=0, out_data=0.
- d_be = ((1<<s)-1) << a.
- d_data_w = the low s bytes of in_reg_data replicated across all lanes.
- Load result: d_data_r >> (8*a), truncated to s bytes, then sign-extended if in_signed, else zero-extended. It is captured on the ack edge.
- pend_we / pend_wsel: reflect the op held in PASS, MEM or RESP with regs_we=1 and no misalign; otherwise pend_we=0.

Test Plan:
- Reset, then 3 back-to-back non-mem ops writing r1=0x11, r2=0x22, r3=0x33 → out_valid high on 3 consecutive cycles starting the cycle after the first accept; in_ready stays 1.
- Word load from 0x100, d_ack after 3 cycles with d_data_r=0xDEADBEEF:
  - d_req held 3 cycles with d_addr=0x100 and d_be=0xF.
  - in_ready=0 throughout.
  - out_data=0xDEADBEEF one cycle after ack.
- Signed byte load from 0x103 with d_data_r=0x80FF0000 → out_data=0xFFFFFF80; the same load unsigned → 0x00000080.
- Half store of 0x1234ABCD at 0x102 → d_be=0xC, d_data_w=0xABCDABCD, d_we=1; out_valid pulse with out_we=0.
- Word load at 0x101 → no d_req; out_valid with misalign=1 and out_we=0 at t+1.
- Reset asserted during MEM, with d_ack arriving the cycle after → d_req=0, out_valid=0, in_ready=1; no spurious result.

Source files
------------

// File: rtl/mem_stage_hs.sv
// Memory stage with valid/ready intake and req/ack data-memory port; byte/half/word/dword access.
// Latency: non-mem and misaligned ops 1 cycle; mem ops 1 cycle to request, result 1 cycle after d_ack.
// Backpressure: in_ready drops only while a memory request is outstanding; results are never stalled.
module mem_stage_hs #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int RSELW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_alu_data,
    input  logic [DW-1:0]    in_reg_data,
    input  logic             in_mem_we,
    input  logic             in_mem_re,
    input  logic [1:0]       in_size,
    input  logic             in_signed,
    input  logic             in_regs_we,
    input  logic [RSELW-1:0] in_regs_wsel,
    output logic             d_req,
    output logic [AW-1:0]    d_addr,
    output logic             d_we,
    output logic [DW/8-1:0]  d_be,
    output logic [DW-1:0]    d_data_w,
    input  logic             d_ack,
    input  logic [DW-1:0]    d_data_r,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic [RSELW-1:0] out_wsel,
    output logic             out_we,
    output logic             misalign,
    output logic             pend_we,
    output logic [RSELW-1:0] pend_wsel
);
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_MEM, ST_RESP} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             dwe_q, dwe_d;
    logic [NB-1:0]    be_q, be_d;
    logic [DW-1:0]    dw_q, dw_d;
    logic [DW-1:0]    data_q, data_d;
    logic             we_q, we_d;
    logic [RSELW-1:0] wsel_q, wsel_d;
    logic             mis_q, mis_d;
    logic             sgn_q, sgn_d;
    logic [1:0]       size_q, size_d;
    logic [LB-1:0]    lane_q, lane_d;

    logic             is_mem, fault;
    logic [NB-1:0]    be_new;
    logic [DW-1:0]    dw_new;
    int               s_bytes, a_off;
    logic [DW-1:0]    ld_sh, ld_mask, ld_val;
    int               ld_bits;

    // Decode the presented op: access size, alignment fault, byte enables, lane-replicated store data.
    always_comb begin
        s_bytes = 1 << in_size;
        a_off   = int'(in_alu_data[LB-1:0]);
        is_mem  = in_mem_we | in_mem_re;
        fault   = is_mem && (((in_size == 2'd3) && (DW == 32)) || ((a_off & (s_bytes - 1)) != 0));
        be_new  = NB'(((1 << s_bytes) - 1) << a_off);
        dw_new  = '0;
        for (int i = 0; i < NB; i++) begin
            dw_new[8*i +: 8] = in_reg_data[8*(i & (s_bytes - 1)) +: 8];
        end
    end

    // Extract the addressed bytes from the read data and extend to full width.
    always_comb begin
        ld_sh   = d_data_r >> {lane_q, 3'b000};
        ld_bits = 8 << size_q;
        if (ld_bits > DW) ld_bits = DW;
        ld_mask = '1;
        if (ld_bits < DW) ld_mask = (DW'(1) << ld_bits) - DW'(1);
        ld_val  = ld_sh & ld_mask;
        if (sgn_q && ld_sh[ld_bits-1]) ld_val = ld_val | ~ld_mask;
    end

    // Next state and held-op fields; any non-MEM state can take a new op every cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dwe_d   = dwe_q;
        be_d    = be_q;
        dw_d    = dw_q;
        data_d  = data_q;
        we_d    = we_q;
        wsel_d  = wsel_q;
        mis_d   = mis_q;
        sgn_d   = sgn_q;
        size_d  = size_q;
        lane_d  = lane_q;
        case (state_q)
            ST_MEM: begin
                if (d_ack) begin
                    state_d = ST_RESP;
                    data_d  = dwe_q ? '0 : ld_val;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (in_valid) begin
                    wsel_d = in_regs_wsel;
                    sgn_d  = in_signed;
                    size_d = in_size;
                    lane_d = in_alu_data[LB-1:0];
                    if (!is_mem) begin
                        state_d = ST_PASS;
                        data_d  = DW'(in_alu_data);
                        we_d    = in_regs_we;
                        mis_d   = 1'b0;
                    end else if (fault) begin
                        state_d = ST_RESP;
                        data_d  = '0;
                        we_d    = 1'b0;
                        mis_d   = 1'b1;
                    end else begin
                        // A store wins when both read and write are flagged; stores never write a register.
                        state_d = ST_MEM;
                        addr_d  = in_alu_data & ~AW'(NB - 1);
                        dwe_d   = in_mem_we;
                        be_d    = be_new;
                        dw_d    = dw_new;
                        we_d    = in_regs_we && !in_mem_we;
                        mis_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    // State and held-op registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dwe_q   <= 1'b0;
            be_q    <= '0;
            dw_q    <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            wsel_q  <= '0;
            mis_q   <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dwe_q   <= dwe_d;
            be_q    <= be_d;
            dw_q    <= dw_d;
            data_q  <= data_d;
            we_q    <= we_d;
            wsel_q  <= wsel_d;
            mis_q   <= mis_d;
            sgn_q   <= sgn_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
        end
    end

    assign in_ready  = (state_q != ST_MEM);
    assign d_req     = (state_q == ST_MEM);
    assign d_addr    = addr_q;
    assign d_we      = d_req && dwe_q;
    assign d_be      = d_req ? be_q : '0;
    assign d_data_w  = dw_q;
    assign out_valid = (state_q == ST_PASS) || (state_q == ST_RESP);
    assign out_data  = data_q;
    assign out_wsel  = wsel_q;
    assign out_we    = out_valid && we_q;
    assign misalign  = out_valid && mis_q;
    assign pend_we   = (state_q != ST_IDLE) && we_q && !mis_q;
    assign pend_wsel = pend_we ? wsel_q : '0;
endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;
    localparam int DW = 32, AW = 32, RSELW = 4, NB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             in_valid, in_ready;
    logic [AW-1:0]    in_alu_data;
    logic [DW-1:0]    in_reg_data;
    logic             in_mem_we, in_mem_re, in_signed, in_regs_we;
    logic [1:0]       in_size;
    logic [RSELW-1:0] in_regs_wsel;
    logic             d_req, d_we, d_ack;
    logic [AW-1:0]    d_addr;
    logic [NB-1:0]    d_be;
    logic [DW-1:0]    d_data_w, d_data_r;
    logic             out_valid, out_we, misalign, pend_we;
    logic [DW-1:0]    out_data;
    logic [RSELW-1:0] out_wsel, pend_wsel;

    mem_stage_hs #(.DW(DW), .AW(AW), .RSELW(RSELW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_data(in_alu_data), .in_reg_data(in_reg_data),
        .in_mem_we(in_mem_we), .in_mem_re(in_mem_re), .in_size(in_size), .in_signed(in_signed),
        .in_regs_we(in_regs_we), .in_regs_wsel(in_regs_wsel),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_data_w(d_data_w),
        .d_ack(d_ack), .d_data_r(d_data_r),
        .out_valid(out_valid), .out_data(out_data), .out_wsel(out_wsel), .out_we(out_we),
        .misalign(misalign), .pend_we(pend_we), .pend_wsel(pend_wsel)
    );

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic [3:0]  wsel;
        logic        mis;
        logic        chk_data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] dw;
        int          lat;
        logic [31:0] rdata;
        logic        pend;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   total = 0;
    int   bad = 0;
    bit   resp_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: what writeback and memory should see for one op, from the access rules.
    function automatic void model(input logic [31:0] addr, input logic [31:0] rd, input logic mwe,
                                  input logic mre, input logic [1:0] size, input logic sgn,
                                  input logic rwe, input logic [3:0] wsel, input int lat,
                                  input logic [31:0] rdata, output exp_t e, output req_t r,
                                  output bit is_req);
        int s = 1 << size;
        int a = int'(addr % 4);
        longint unsigned mask, v;
        logic [31:0] dw;
        e.wsel = wsel; e.mis = 1'b0; e.chk_data = 1'b1; e.data = '0; e.we = 1'b0;
        r.addr = '0; r.we = 1'b0; r.be = '0; r.dw = '0; r.lat = lat; r.rdata = rdata; r.pend = 1'b0;
        is_req = 1'b0;
        if (!(mwe || mre)) begin
            e.data = addr;
            e.we   = rwe;
        end else if (size == 2'd3 || (a % s) != 0) begin
            e.mis = 1'b1;
        end else begin
            is_req = 1'b1;
            r.addr = addr - 32'(a);
            r.we   = mwe;
            r.be   = 4'(((1 << s) - 1) << a);
            for (int i = 0; i < 4; i++) dw[8*i +: 8] = rd[8*(i % s) +: 8];
            r.dw = dw;
            if (mwe) begin
                e.chk_data = 1'b0;
            end else begin
                mask = (64'd1 << (8 * s)) - 64'd1;
                v = (64'(rdata) >> (8 * a)) & mask;
                if (sgn && v[8*s-1]) v = v | ~mask;
                e.data = v[31:0];
                e.we   = rwe;
            end
            r.pend = e.we;
        end
    endfunction

    // Present one op, wait for acceptance, and record what must come back.
    task automatic issue(input logic [31:0] addr, input logic [31:0] rd, input logic mwe, input logic mre,
                         input logic [1:0] size, input logic sgn, input logic rwe, input logic [3:0] wsel,
                         input int lat, input logic [31:0] rdata);
        exp_t e; req_t r; bit isr; bit ok;
        model(addr, rd, mwe, mre, size, sgn, rwe, wsel, lat, rdata, e, r, isr);
        in_valid = 1'b1; in_alu_data = addr; in_reg_data = rd; in_mem_we = mwe; in_mem_re = mre;
        in_size = size; in_signed = sgn; in_regs_we = rwe; in_regs_wsel = wsel;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready stuck at %0b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        if (isr) req_q.push_back(r);
        #1 in_valid = 1'b0;
    endtask

    // Memory model: checks each request while held, acks after its latency, and injects stray acks.
    initial begin : responder
        req_t cur;
        bit   active = 1'b0;
        int   cyc = 0;
        logic prev_rst = 1'b1;
        d_ack = 1'b0; d_data_r = '0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            d_ack = 1'b0;
            if (!resp_en) begin
                if (prev_rst && !reset) begin
                    d_ack = 1'b1; d_data_r = 32'hBAD0_BAD0;
                end
            end else if (d_req) begin
                if (!active) begin
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_d_req: d_req=1 with no request outstanding, required 0");
                    end else begin
                        cur = req_q.pop_front(); active = 1'b1; cyc = 0;
                    end
                end
                if (active) begin
                    cyc++;
                    chk("d_addr", 64'(d_addr), 64'(cur.addr));
                    chk("d_we", 64'(d_we), 64'(cur.we));
                    chk("d_be", 64'(d_be), 64'(cur.be));
                    chk("d_data_w", 64'(d_data_w), 64'(cur.dw));
                    chk("in_ready_in_mem", 64'(in_ready), 64'd0);
                    chk("pend_we_mem", 64'(pend_we), 64'(cur.pend));
                    if (cyc == cur.lat + 1) begin
                        d_ack = 1'b1; d_data_r = cur.rdata; active = 1'b0;
                    end
                end
            end else if (!reset && $urandom_range(0, 7) == 0) begin
                d_ack = 1'b1; d_data_r = $urandom;
            end
            prev_rst = reset;
        end
    end

    // Writeback monitor: every result pulse must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out_valid: out_valid=1 data=%0h, required no result", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_data) chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_we", 64'(out_we), 64'(e.we));
                    chk("out_wsel", 64'(out_wsel), 64'(e.wsel));
                    chk("misalign", 64'(misalign), 64'(e.mis));
                    chk("pend_we_out", 64'(pend_we), 64'(e.we));
                    if (e.we) chk("pend_wsel", 64'(pend_wsel), 64'(e.wsel));
                end
            end
        end
    end

    initial begin : main
        logic [31:0] addr, rd;
        logic [1:0]  size;
        logic        mwe, mre, rwe;
        int          kind;
        reset = 1'b1; in_valid = 1'b0; in_alu_data = '0; in_reg_data = '0; in_mem_we = 1'b0;
        in_mem_re = 1'b0; in_size = '0; in_signed = 1'b0; in_regs_we = 1'b0; in_regs_wsel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_d_req", 64'(d_req), 64'd0);
        chk("rst_pend_we", 64'(pend_we), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        chk("rst_d_be", 64'(d_be), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases.
        issue(32'h11, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'd1, 0, 32'h0);
        issue(32'h22, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'd2, 0, 32'h0);
        issue(32'h33, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'd3, 0, 32'h0);
        issue(32'h100, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'd4, 2, 32'hDEADBEEF);
        issue(32'h103, 32'h0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 4'd5, 0, 32'h80FF0000);
        issue(32'h103, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'd6, 1, 32'h80FF0000);
        issue(32'h102, 32'h1234ABCD, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 4'd0, 0, 32'h0);
        issue(32'h101, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'd7, 0, 32'h0);
        issue(32'h204, 32'h55667788, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'd8, 1, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            addr = $urandom; rd = $urandom;
            size = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) size = 2'd3;
            mwe = 1'b0; mre = 1'b0; rwe = 1'($urandom);
            if (kind >= 3 && kind <= 6) mre = 1'b1;
            if (kind >= 7) begin mwe = 1'b1; mre = 1'($urandom); rwe = 1'b0; end
            if ((mwe || mre) && $urandom_range(0, 9) < 8) addr = addr & ~((32'd1 << size) - 32'd1);
            issue(addr, rd, mwe, mre, size, 1'($urandom), rwe, 4'($urandom), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end

        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset while a load is outstanding, with an ack arriving the cycle after.
        resp_en = 1'b0;
        in_valid = 1'b1; in_alu_data = 32'h200; in_mem_re = 1'b1; in_mem_we = 1'b0;
        in_size = 2'd2; in_regs_we = 1'b1; in_regs_wsel = 4'd9;
        @(negedge clk);
        chk("rr_ready_before", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rr_d_req_mem", 64'(d_req), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rr_d_req", 64'(d_req), 64'd0);
        chk("rr_out_valid", 64'(out_valid), 64'd0);
        chk("rr_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("rr_no_late_result", 64'(out_valid), 64'd0);
        chk("rr_d_req_after", 64'(d_req), 64'd0);
        chk("rr_pend_we", 64'(pend_we), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
